delay_sum_beamformer: RTL and testbench
=======================================

Name: delay_sum_beamformer

Overview:
- Consumes the four per-mic cycle delays produced by the angle-to-delay lookup stage, plus one PCM sample per microphone per audio sample strobe.
- Delays each mic stream by its delay_k samples in a circular buffer and sums the four aligned samples into one steered output sample.
- Sits between the mic deserialisers/decimators upstream and the output/audio stage downstream.

Parameters:
- SAMPLE_WIDTH, 16, signed width of each mic sample.
- DEPTH, 16, entries per mic delay line; power of two; maximum honoured delay is DEPTH-1.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous, active-low reset
- sample_valid_in  input  1  one-cycle strobe: mic_k_in valid, advance delay lines
- mic_1_in .. mic_4_in  input  SAMPLE_WIDTH each  signed mic samples
- delay_1_in .. delay_4_in  input  8 each  unsigned per-mic delay in samples, from the angle-to-delay lookup stage
- sum_out  output  SAMPLE_WIDTH+2  signed steered sample
- sum_valid_out  output  1  one-cycle strobe: sum_out updated

Behaviour:
- Reset (rst_in low at a clock edge): wr_ptr=0, fill_count=0, state=FILL, pipeline valids=0, sum_out=0, sum_valid_out=0. Buffer contents are not cleared; fill_count masks them. Reset mid-operation drops in-flight samples; no sum_valid_out follows.
- Delay clamp: eff_d_k = min(delay_k_in, DEPTH-1), sampled in the sample_valid_in cycle. Delay changes take effect on the next strobe; no re-warm.
- Stage 0 (cycle N, sample_valid_in=1):
  - Write mic_k_in to buf_k[wr_ptr].
  - eff_d_k=0: capture mic_k_in (bypass).
  - eff_d_k≥1: capture buf_k[(wr_ptr-eff_d_k) mod DEPTH], or 0 if eff_d_k > fill_count.
  - wr_ptr increments, wrapping DEPTH-1→0.
- Stage 1 (cycle N+1): sign-extend the four aligned samples to SAMPLE_WIDTH+2 and sum. Register sum_out at cycle N+2 with sum_valid_out=1 for that one cycle.
- Latency: exactly 2 cycles from sample_valid_in to sum_valid_out. Back-to-back strobes on every cycle are supported (throughput 1/cycle).
- No stall/backpressure; a downstream stage must accept every sum_valid_out.
- Between strobes, sum_out holds its last value.
- State machine:
  - FILL: fill_count increments on each strobe.
  - FILL→RUN when fill_count reaches DEPTH-1.
  - RUN: fill_count saturates at DEPTH-1; the state leaves RUN only on reset.
- Arithmetic: full-precision sum, no overflow possible. Range is ±4·2^(SAMPLE_WIDTH-1).

Optional Feature:
- Macro BEAMFORM_AVERAGE_EN.
- Defined: sum_out = arithmetic right shift by 2 of the full sum (truncation toward −inf), sign-extended to SAMPLE_WIDTH+2. Latency is unchanged.
- Undefined: raw full-precision sum.

Decomposition:
- Package beamform_pkg: NUM_MICS=4, SAMPLE_WIDTH, DEPTH, PTR_WIDTH=$clog2(DEPTH), typedef sample_t (signed SAMPLE_WIDTH), typedef sum_t (signed SAMPLE_WIDTH+2), typedef delay_t (8-bit unsigned).
- One sub-module, mic_delay_line, instantiated 4×. It contains the buffer, the delay clamp, the bypass path, the fill masking and the stage-0 register. wr_ptr and fill_count are shared and passed in from the top.

Test Plan:
- Reset: hold rst_in=0 for 3 cycles with strobes active → sum_out=0, sum_valid_out=0 throughout and for 2 cycles after release.
- Zero delay: delays 0,0,0,0; mics 100,200,300,400; one strobe at cycle N → sum_out=1000 with sum_valid_out=1 exactly at N+2.
- Steering: after ≥16 zero-sample strobes, delays 0,5,10,15; impulse 1000 on all mics at strobe 0, then zeros → outputs 1000 at strobes 0,5,10,15 and 0 elsewhere.
- Warm-up masking: after reset, delay_4=15, others 0; mic_4=7 constant, others 0 → first 15 outputs are 0, output 16 onward is 7.
- Clamp/extremes: delay_1=200, all mics −32768 constant in RUN state → sum_out=−131072. With BEAMFORM_AVERAGE_EN defined → −32768.
- Pointer wrap and reset mid-run: 40 back-to-back strobes with ramp data and delay 3 → output = ramp−3 across wrap. Assert rst_in mid-stream → no stray sum_valid_out, and the masking restarts.

Source files
------------

// File: rtl/delay_sum_beamformer_pkg.sv
// beamform_pkg: shared constants and types for delay_sum_beamformer
package beamform_pkg;
    localparam int NUM_MICS     = 4;
    localparam int SAMPLE_WIDTH = 16;
    localparam int DEPTH        = 16;
    localparam int PTR_WIDTH    = $clog2(DEPTH);
    typedef logic signed [SAMPLE_WIDTH-1:0] sample_t;
    typedef logic signed [SAMPLE_WIDTH+1:0] sum_t;
    typedef logic [7:0] delay_t;
    typedef enum logic {FILL, RUN} state_t;
endpackage

// File: rtl/delay_sum_beamformer_mic_delay_line.sv
// mic_delay_line: per-mic circular delay buffer with delay clamp, zero-delay bypass,
// warm-up masking and the stage-0 aligned-sample register
module mic_delay_line
    import beamform_pkg::*;
(
    input  logic                        clk_in,
    input  logic                        valid,
    input  logic signed [SAMPLE_WIDTH-1:0] mic,
    input  logic [7:0]                  delay,
    input  logic [PTR_WIDTH-1:0]        wr_ptr,
    input  logic [PTR_WIDTH-1:0]        fill_count,
    output logic signed [SAMPLE_WIDTH-1:0] aligned
);
    sample_t              mem [DEPTH];
    sample_t              tap;
    logic [PTR_WIDTH-1:0] eff;
    // entries older than fill_count were never written since reset, so they read as silence
    always_comb begin
        eff = (delay > delay_t'(DEPTH - 1)) ? PTR_WIDTH'(DEPTH - 1) : delay[PTR_WIDTH-1:0];
        tap = (eff == '0) ? mic : (eff > fill_count) ? '0 : mem[wr_ptr - eff];
    end
    always_ff @(posedge clk_in) begin
        if (valid) begin
            mem[wr_ptr] <= mic;
            aligned     <= tap;
        end
    end
endmodule

// File: rtl/delay_sum_beamformer.sv
// delay_sum_beamformer: four-mic delay-and-sum steering, two-cycle strobe-to-output latency
// BEAMFORM_AVERAGE_EN: output the sum arithmetically shifted right by 2 instead of the raw sum
module delay_sum_beamformer
    import beamform_pkg::*;
(
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic                           sample_valid_in,
    input  logic signed [SAMPLE_WIDTH-1:0] mic_1_in,
    input  logic signed [SAMPLE_WIDTH-1:0] mic_2_in,
    input  logic signed [SAMPLE_WIDTH-1:0] mic_3_in,
    input  logic signed [SAMPLE_WIDTH-1:0] mic_4_in,
    input  logic [7:0]                     delay_1_in,
    input  logic [7:0]                     delay_2_in,
    input  logic [7:0]                     delay_3_in,
    input  logic [7:0]                     delay_4_in,
    output logic signed [SAMPLE_WIDTH+1:0] sum_out,
    output logic                           sum_valid_out
);
    state_t               state, state_n;
    logic [PTR_WIDTH-1:0] wr_ptr, fill_count, fill_n;
    logic                 v0;
    sample_t              mic [NUM_MICS];
    delay_t               delay [NUM_MICS];
    sample_t              aligned [NUM_MICS];
    sum_t                 total, result;
    assign mic   = '{mic_1_in, mic_2_in, mic_3_in, mic_4_in};
    assign delay = '{delay_1_in, delay_2_in, delay_3_in, delay_4_in};
    for (genvar i = 0; i < NUM_MICS; i++) begin : g_mic
        mic_delay_line u_line (
            .clk_in    (clk_in),
            .valid     (sample_valid_in),
            .mic       (mic[i]),
            .delay     (delay[i]),
            .wr_ptr    (wr_ptr),
            .fill_count(fill_count),
            .aligned   (aligned[i])
        );
    end
    always_comb begin
        state_n = state;
        fill_n  = fill_count;
        if (sample_valid_in && state == FILL) begin
            fill_n  = fill_count + PTR_WIDTH'(1);
            state_n = (fill_n == PTR_WIDTH'(DEPTH - 1)) ? RUN : FILL;
        end
    end
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state      <= FILL;
            fill_count <= '0;
        end else begin
            state      <= state_n;
            fill_count <= fill_n;
        end
    end
    always_comb begin
        total = '0;
        for (int k = 0; k < NUM_MICS; k++) total = total + sum_t'(aligned[k]);
`ifdef BEAMFORM_AVERAGE_EN
        result = total >>> 2;
`else
        result = total;
`endif
    end
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            wr_ptr        <= '0;
            v0            <= 1'b0;
            sum_out       <= '0;
            sum_valid_out <= 1'b0;
        end else begin
            if (sample_valid_in) wr_ptr <= wr_ptr + PTR_WIDTH'(1);
            v0            <= sample_valid_in;
            sum_valid_out <= v0;
            if (v0) sum_out <= result;
        end
    end
endmodule

// File: tb/tb_delay_sum_beamformer.sv
// tb_delay_sum_beamformer: scoreboard bench for delay_sum_beamformer, honours BEAMFORM_AVERAGE_EN
module tb_delay_sum_beamformer;
    localparam int DMAX = 15;
    logic               clk_in = 1'b0;
    logic               rst_in = 1'b0;
    logic               sample_valid_in = 1'b0;
    logic signed [15:0] mic_1_in = '0, mic_2_in = '0, mic_3_in = '0, mic_4_in = '0;
    logic [7:0]         delay_1_in = '0, delay_2_in = '0, delay_3_in = '0, delay_4_in = '0;
    logic signed [17:0] sum_out;
    logic               sum_valid_out;
    typedef struct {int due; int val;} exp_t;
    exp_t q[$];
    int   hist [4][1024];
    int   n = 0;
    int   cyc = 0;
    int   checks = 0;
    int   passed = 0;
    delay_sum_beamformer dut (
        .clk_in(clk_in), .rst_in(rst_in), .sample_valid_in(sample_valid_in),
        .mic_1_in(mic_1_in), .mic_2_in(mic_2_in), .mic_3_in(mic_3_in), .mic_4_in(mic_4_in),
        .delay_1_in(delay_1_in), .delay_2_in(delay_2_in), .delay_3_in(delay_3_in), .delay_4_in(delay_4_in),
        .sum_out(sum_out), .sum_valid_out(sum_valid_out)
    );
    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;
    function automatic int scale(input int s);
`ifdef BEAMFORM_AVERAGE_EN
        return s >>> 2;
`else
        return s;
`endif
    endfunction
    task automatic step(input bit rn, input bit v, input int m1, m2, m3, m4, input int d1, d2, d3, d4);
        int m[4];
        int d[4];
        int s;
        m = '{m1, m2, m3, m4};
        d = '{d1, d2, d3, d4};
        @(posedge clk_in);
        #1;
        rst_in = rn;
        sample_valid_in = v;
        mic_1_in = 16'(m1); mic_2_in = 16'(m2); mic_3_in = 16'(m3); mic_4_in = 16'(m4);
        delay_1_in = 8'(d1); delay_2_in = 8'(d2); delay_3_in = 8'(d3); delay_4_in = 8'(d4);
        if (!rn) begin
            while (q.size() > 0 && q[$].due > cyc) void'(q.pop_back());
            n = 0;
        end else if (v) begin
            s = 0;
            for (int k = 0; k < 4; k++) begin
                int e;
                e = d[k] > DMAX ? DMAX : d[k];
                if (e == 0) s += m[k];
                else if (e <= n) s += hist[k][n - e];
                hist[k][n] = m[k];
            end
            q.push_back('{cyc + 2, scale(s)});
            n++;
        end
    endtask
    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask
    initial forever begin
        exp_t e;
        @(negedge clk_in);
        if (sum_valid_out === 1'b1) begin
            checks++;
            if (q.size() == 0) $display("FAIL stray_valid cyc=%0d sum_out=%0d required no output", cyc, sum_out);
            else begin
                e = q.pop_front();
                if (e.due != cyc || sum_out !== 18'(e.val))
                    $display("FAIL scoreboard cyc=%0d sum_out=%0d required cyc=%0d sum=%0d", cyc, sum_out, e.due, e.val);
                else passed++;
            end
        end else if (q.size() > 0 && q[0].due <= cyc) begin
            checks++;
            e = q.pop_front();
            $display("FAIL missing_valid cyc=%0d sum_valid_out=%b required valid with sum=%0d", cyc, sum_valid_out, e.val);
        end
    end
    task automatic test_reset();
        for (int i = 0; i < 6; i++) begin
            step(i >= 3, i < 3, 11, 22, 33, 44, 0, 0, 0, 0);
            @(negedge clk_in);
            checks++;
            if (sum_valid_out !== 1'b0 || sum_out !== 18'sd0)
                $display("FAIL reset_%0d sum_valid_out=%b sum_out=%0d required 0/0", i, sum_valid_out, sum_out);
            else passed++;
        end
    endtask
    task automatic test_zero_delay();
        step(1, 1, 100, 200, 300, 400, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk_in);
        checks++;
        if (sum_valid_out !== 1'b0) $display("FAIL zero_delay_early valid=%b required 0", sum_valid_out);
        else passed++;
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk_in);
        checks++;
        if (sum_valid_out !== 1'b1 || sum_out !== 18'(scale(1000)))
            $display("FAIL zero_delay_n2 valid=%b sum_out=%0d required 1/%0d", sum_valid_out, sum_out, scale(1000));
        else passed++;
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk_in);
        checks++;
        if (sum_valid_out !== 1'b0 || sum_out !== 18'(scale(1000)))
            $display("FAIL zero_delay_hold valid=%b sum_out=%0d required 0/%0d", sum_valid_out, sum_out, scale(1000));
        else passed++;
    endtask
    task automatic test_steering();
        for (int i = 0; i < 16; i++) step(1, 1, 0, 0, 0, 0, 0, 5, 10, 15);
        step(1, 1, 1000, 1000, 1000, 1000, 0, 5, 10, 15);
        for (int i = 0; i < 19; i++) step(1, 1, 0, 0, 0, 0, 0, 5, 10, 15);
        idle(3);
    endtask
    task automatic test_warmup();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) step(1, 1, 0, 0, 0, 7, 0, 0, 0, 15);
        idle(3);
    endtask
    task automatic test_clamp();
        for (int i = 0; i < 20; i++) step(1, 1, -32768, -32768, -32768, -32768, 200, 0, 0, 0);
        idle(3);
        checks++;
        if (sum_out !== 18'(scale(-131072)))
            $display("FAIL clamp_extreme sum_out=%0d required %0d", sum_out, scale(-131072));
        else passed++;
    endtask
    task automatic test_wrap_reset();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 40; i++) step(1, 1, i, i, i, i, 3, 3, 3, 3);
        idle(3);
        checks++;
        if (sum_out !== 18'(scale(4 * 36)))
            $display("FAIL wrap_ramp sum_out=%0d required %0d", sum_out, scale(4 * 36));
        else passed++;
        for (int i = 40; i < 45; i++) step(1, 1, i, i, i, i, 3, 3, 3, 3);
        step(0, 1, 99, 99, 99, 99, 3, 3, 3, 3);
        step(1, 1, 0, 0, 0, 0, 3, 3, 3, 3);
        @(negedge clk_in);
        checks++;
        if (sum_valid_out !== 1'b0) $display("FAIL reset_drop_1 valid=%b required 0", sum_valid_out);
        else passed++;
        step(1, 1, 1, 1, 1, 1, 3, 3, 3, 3);
        @(negedge clk_in);
        checks++;
        if (sum_valid_out !== 1'b0) $display("FAIL reset_drop_2 valid=%b required 0", sum_valid_out);
        else passed++;
        for (int i = 2; i < 8; i++) step(1, 1, i, i, i, i, 3, 3, 3, 3);
        idle(3);
        checks++;
        if (sum_out !== 18'(scale(4 * 4)))
            $display("FAIL reset_remask sum_out=%0d required %0d", sum_out, scale(4 * 4));
        else passed++;
    endtask
    initial begin
        test_reset();
        test_zero_delay();
        test_steering();
        test_warmup();
        test_clamp();
        test_wrap_reset();
        idle(4);
        checks++;
        if (q.size() != 0) $display("FAIL drain pending=%0d required 0", q.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
